// File: rtl/seg_mux_ctrl.sv
// Time-multiplexed 7-segment digit scanner: blank dead-time, then drive each digit slot in turn.
// Optional leading-zero blanking is compiled in with `define SEG_MUX_LZB_EN.
module seg_mux_ctrl #(
  parameter int NUM_DIGITS   = 2,
  parameter int REFRESH_DIV  = 24000,
  parameter int BLANK_CYCLES = 240
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  output logic [3:0]                    hex_sel,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [IDX_W-1:0]        idx_nxt;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] shown;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic                    load_pending;
  logic                    slot_start, slot_start_nxt;
  logic                    snap;

`ifdef SEG_MUX_LZB_EN
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  zero_run;

  // lead_zero[i]: nibble i and every higher nibble are zero
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (shadow[4*i +: 4] == 4'h0);
      lead_zero[i] = zero_run;
    end
  end
`endif

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt + 1'b1;
    idx_nxt        = digit_idx;
    slot_start_nxt = 1'b0;
    snap           = load_pending;
    an_nxt         = '1;
    case (state)
      BLANK: begin
        if (BLANK_CYCLES == 0 || cnt == BLANK_LAST) begin
          state_nxt = DRIVE;
          cnt_nxt   = '0;
        end
      end
      DRIVE: begin
        if (cnt == DRIVE_LAST) begin
          state_nxt      = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
          cnt_nxt        = '0;
          slot_start_nxt = 1'b1;
          if (digit_idx == IDX_LAST) begin
            idx_nxt = '0;
            snap    = 1'b1;
          end else begin
            idx_nxt = digit_idx + 1'b1;
          end
        end
      end
      default: state_nxt = BLANK;
    endcase
    if (state_nxt == DRIVE) begin
`ifdef SEG_MUX_LZB_EN
      if (idx_nxt == '0 || !lead_zero[idx_nxt]) an_nxt[idx_nxt] = 1'b0;
`else
      an_nxt[idx_nxt] = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= BLANK;
      cnt          <= '0;
      digit_idx    <= '0;
      an           <= '1;
      shadow       <= '0;
      load_pending <= 1'b1;
      slot_start   <= 1'b1;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      digit_idx    <= idx_nxt;
      an           <= an_nxt;
      load_pending <= 1'b0;
      slot_start   <= slot_start_nxt;
      if (snap) shadow <= digits;
    end
  end

  // First cycle after reset the snapshot is still in flight, so show the live value it is taking
  assign shown      = (load_pending && !reset) ? digits : shadow;
  assign hex_sel    = shown[{digit_idx, 2'b00} +: 4];
  assign frame_tick = !reset && slot_start && (digit_idx == '0);

endmodule

// File: tb/tb_seg_mux_ctrl.sv
// Bench for seg_mux_ctrl: vector table, hand sequences, and a randomized frame-level model.
module tb_seg_mux_ctrl;
  localparam int N = 2, R = 4, B = 2, P = B + R, F = N * P;
`ifdef SEG_MUX_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1, reset_nb = 1'b1;
  logic [7:0] digits = 8'h00, digits_nb = 8'h00;
  logic [3:0] hex_sel, hex_sel_nb;
  logic [1:0] an, an_nb;
  logic       digit_idx, digit_idx_nb;
  logic       frame_tick, frame_tick_nb;
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  seg_mux_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .digits(digits), .hex_sel(hex_sel),
    .an(an), .digit_idx(digit_idx), .frame_tick(frame_tick));

  seg_mux_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(0)) dut_nb (
    .clk(clk), .reset(reset_nb), .digits(digits_nb), .hex_sel(hex_sel_nb),
    .an(an_nb), .digit_idx(digit_idx_nb), .frame_tick(frame_tick_nb));

  typedef struct {
    int         count;
    logic [7:0] dig;
    logic [1:0] an;
    logic [3:0] hex;
    logic       idx;
    logic       tick_first;
  } seg_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rand_digits();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return {4'h0, 4'($urandom_range(0, 15))};
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // Expected outputs derived from cycle position within the frame and a per-frame snapshot
  task automatic run_model(input int cycles);
    logic [7:0] snap, shown;
    int fpos, slot, off, last_tick;
    logic drive, lz;
    logic [1:0] exp_an;
    snap = 8'h00;
    last_tick = -1;
    for (int t = 0; t < cycles; t++) begin
      @(negedge clk);
      fpos  = t % F;
      slot  = fpos / P;
      off   = fpos % P;
      shown = (t == 0) ? digits : snap;
      drive = (off >= B);
      lz    = (slot > 0) && ((shown >> (4 * slot)) == 8'h00);
      exp_an = (drive && !(LZB && lz)) ? ~(2'b01 << slot) : 2'b11;
      check($sformatf("model_an t=%0d", t), 32'(an), 32'(exp_an));
      check($sformatf("model_hex t=%0d", t), 32'(hex_sel), 32'(shown[slot*4 +: 4]));
      check($sformatf("model_idx t=%0d", t), 32'(digit_idx), 32'(slot));
      check($sformatf("model_tick t=%0d", t), 32'(frame_tick), 32'(fpos == 0));
      check($sformatf("onecold t=%0d", t), 32'($countones(~an) <= 1), 32'd1);
      if (frame_tick) begin
        if (last_tick >= 0) check($sformatf("tick_period t=%0d", t), 32'(t - last_tick), 32'(F));
        last_tick = t;
      end
      if (t == 0 || fpos == F - 1) snap = digits;
      @(posedge clk);
      #1;
      if ($urandom_range(0, 7) == 0) digits = rand_digits();
    end
  endtask

  task automatic run_hand(input logic [7:0] dig);
    logic [7:0] d;
    d = dig;
    digits = d;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < F; c++) begin
      @(negedge clk);
      if (c == 2) begin
        check($sformatf("hand_an0 %0h", d), 32'(an), 32'(2'b10));
        check($sformatf("hand_hex0 %0h", d), 32'(hex_sel), 32'(d[3:0]));
      end
      if (c == 8) begin
        check($sformatf("hand_an1 %0h", d), 32'(an),
              32'((LZB && d[7:4] == 4'h0) ? 2'b11 : 2'b01));
        check($sformatf("hand_idx1 %0h", d), 32'(digit_idx), 32'd1);
      end
      @(posedge clk);
      #1;
    end
  endtask

  seg_vec_t vecs[8];

  initial begin
    vecs[0] = '{2, 8'h3A, 2'b11, 4'hA, 1'b0, 1'b1};
    vecs[1] = '{4, 8'h3A, 2'b10, 4'hA, 1'b0, 1'b0};
    vecs[2] = '{2, 8'h3A, 2'b11, 4'h3, 1'b1, 1'b0};
    vecs[3] = '{4, 8'h5C, 2'b01, 4'h3, 1'b1, 1'b0};
    vecs[4] = '{2, 8'h5C, 2'b11, 4'hC, 1'b0, 1'b1};
    vecs[5] = '{4, 8'h5C, 2'b10, 4'hC, 1'b0, 1'b0};
    vecs[6] = '{2, 8'h5C, 2'b11, 4'h5, 1'b1, 1'b0};
    vecs[7] = '{4, 8'h5C, 2'b01, 4'h5, 1'b1, 1'b0};

    // Reset state
    digits = 8'h3A;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_an", 32'(an), 32'(2'b11));
    check("rst_idx", 32'(digit_idx), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    check("rst_hex", 32'(hex_sel), 32'd0);
    reset = 1'b0;

    // Two frames from the table, digits change mid-frame 0
    begin
      int t;
      t = 0;
      foreach (vecs[v]) begin
        for (int k = 0; k < vecs[v].count; k++) begin
          digits = vecs[v].dig;
          @(negedge clk);
          check($sformatf("tbl_an c=%0d", t), 32'(an), 32'(vecs[v].an));
          check($sformatf("tbl_hex c=%0d", t), 32'(hex_sel), 32'(vecs[v].hex));
          check($sformatf("tbl_idx c=%0d", t), 32'(digit_idx), 32'(vecs[v].idx));
          check($sformatf("tbl_tick c=%0d", t), 32'(frame_tick), 32'(vecs[v].tick_first && k == 0));
          @(posedge clk);
          #1;
          t++;
        end
      end
    end

    // Reset asserted mid-DRIVE of slot 1
    begin
      for (int i = 0; i < 2 * F && an !== 2'b01; i++) @(negedge clk);
      check("wait_drive1", 32'(an), 32'(2'b01));
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_an", 32'(an), 32'(2'b11));
      check("midrst_idx", 32'(digit_idx), 32'd0);
      check("midrst_tick", 32'(frame_tick), 32'd0);
      digits = rand_digits();
      @(posedge clk);
      #1 reset = 1'b0;
      run_model(F * 1000);
    end

    // Leading-zero handling
    run_hand(8'h07);
    run_hand(8'h00);
    run_hand(8'h70);

    // No dead-time build
    digits_nb = 8'h21;
    @(posedge clk);
    @(posedge clk);
    #1 reset_nb = 1'b0;
    for (int c = 0; c < 40; c++) begin
      logic [1:0] e_an;
      logic [3:0] e_hex;
      @(negedge clk);
      if (c == 0) begin
        e_an = 2'b11;
        e_hex = 4'h1;
      end else begin
        e_an = (((c - 1) / R) % 2 == 0) ? 2'b10 : 2'b01;
        e_hex = (((c - 1) / R) % 2 == 0) ? 4'h1 : 4'h2;
      end
      check($sformatf("nb_an c=%0d", c), 32'(an_nb), 32'(e_an));
      check($sformatf("nb_hex c=%0d", c), 32'(hex_sel_nb), 32'(e_hex));
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_mux_ctrl.md
Name: seg_mux_ctrl

Overview:
Time-multiplexing controller for a multi-digit common-anode 7-segment display sharing one seven_segment decoder. Cycles through NUM_DIGITS digit slots, presenting each digit's 4-bit value to the shared decoder and enabling that digit's anode. Dead-time blanking between slots prevents ghosting. Sits between lab top-level switch/count logic and the seven_segment decoder plus the anode transistor drive.

Parameters:
NUM_DIGITS, 2, number of multiplexed digits; legal range 2..4.
REFRESH_DIV, 24000, clk cycles each digit is driven (1 ms at 24 MHz); legal range >= 1.
BLANK_CYCLES, 240, dead-time clk cycles with all anodes off before each slot; legal range >= 0.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
digits  input  4*NUM_DIGITS  digit values; nibble i = digits[4i+3:4i], digit 0 = rightmost
hex_sel  output  4  value to shared seven_segment decoder input
an  output  NUM_DIGITS  anode enables, active-low (0 = digit on)
digit_idx  output  $clog2(NUM_DIGITS)  currently selected slot
frame_tick  output  1  one-cycle pulse at start of each frame

Behaviour:
- Clock and reset: clk and reset only; reset is synchronous and active-high, sampled on rising edge of clk.
- Reset values: state=BLANK, digit_idx=0, slot counter=0, an=all 1s, shadow register=0, hex_sel=0, frame_tick=0.
- FSM states: BLANK (all an=1), DRIVE (an[digit_idx]=0, others 1).
- BLANK lasts exactly BLANK_CYCLES cycles, then DRIVE. If BLANK_CYCLES=0, BLANK is skipped; DRIVE follows DRIVE back-to-back with only the idx change.
- DRIVE lasts exactly REFRESH_DIV cycles. On its last cycle: digit_idx <= (digit_idx==NUM_DIGITS-1) ? 0 : digit_idx+1; counter <= 0; state <= BLANK (or DRIVE if BLANK_CYCLES=0).
- Slot period = BLANK_CYCLES+REFRESH_DIV; frame period = NUM_DIGITS*slot period.
- Snapshot: shadow <= digits on the first cycle after reset deasserts and on every idx wrap to 0. Mid-frame changes to digits do not affect the current frame. This guarantees no tearing.
- hex_sel = shadow nibble[digit_idx]; valid throughout BLANK and DRIVE of that slot. This lets the decoder settle during blanking.
- frame_tick=1 for one cycle in the first cycle of slot 0 (after each wrap and the first cycle after reset); 0 otherwise.
- an is registered; never more than one bit low; glitch-free.
- reset asserted mid-slot: all state returns to reset values on the next edge; an goes all 1s that edge.
- Counter width = $clog2(max(REFRESH_DIV,BLANK_CYCLES)+1); no overflow/wrap beyond terminal count.

Optional Feature:
SEG_MUX_LZB_EN (leading-zero blanking)
- Defined: a digit i>0 is blanked if its shadow nibble and all higher-index nibbles are 0. Blanked means an stays all 1s during that slot's DRIVE. Timing, digit_idx, and frame_tick are unchanged. Digit 0 is never blanked.
- Undefined: all digits are always driven, including leading zeros.

Test Plan:
(All with NUM_DIGITS=2, REFRESH_DIV=4, BLANK_CYCLES=2.)
1. Reset, then release with digits=8'h3A. Required:
   - an=2'b11 for 2 cycles, then an=2'b10 for 4 cycles with hex_sel=4'hA.
   - Then an=2'b11 for 2 cycles, then an=2'b01 for 4 cycles with hex_sel=4'h3.
   - frame_tick pulses in cycle 0 and cycle 12.
2. Change digits 8'h3A->8'h5C during slot 1 of frame 0. Required: slot 1 still shows hex_sel=3; frame 1 shows C then 5.
3. Assert reset during DRIVE of slot 1 (an=2'b01). Required: next edge an=2'b11, digit_idx=0, frame_tick=0; normal sequence restarts.
4. BLANK_CYCLES=0 build. Required: an alternates 2'b10/2'b01 every 4 cycles with no all-1s cycle; never 2'b00.
5. SEG_MUX_LZB_EN defined, digits=8'h07. Required: slot 1 DRIVE has an=2'b11 and slot 0 shows 7. With digits=8'h00, slot 0 still drives an=2'b10 with hex_sel=0.
6. Continuous check over 1000 frames: an never has more than one 0 bit; frame_tick period is exactly 12 cycles.
